// File: rtl/interconnect_reg_slave_pkg.sv
// Shared widths, register indices and FSM state encoding for the interconnect
// register slave.
package interconnect_reg_slave_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned ALIGN_W        = $clog2(WORD_W / BYTE_W);
  localparam int unsigned REG_IDX_ID     = 0;
  localparam int unsigned REG_IDX_STATUS = 1;
  localparam int unsigned STATE_W        = 6;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 6'b000001,
    ADDR_ACK   = 6'b000010,
    WAIT_WDATA = 6'b000100,
    WDATA_ACK  = 6'b001000,
    READ_WAIT  = 6'b010000,
    READ_VALID = 6'b100000
  } state_t;

endpackage

// File: rtl/interconnect_reg_slave_if.sv
// Word interconnect handshake bundle: address, write data and read data share
// the i_common / o_read_data buses.
interface interconnect_reg_slave_if;
  import interconnect_reg_slave_pkg::*;

  logic              i_addr_valid;
  logic              i_write_enable;
  logic              i_write_data_valid;
  logic              i_read_data_ready;
  logic [WORD_W-1:0] i_common;
  logic              o_addr_ready;
  logic              o_write_data_ready;
  logic              o_read_data_valid;
  logic [WORD_W-1:0] o_read_data;

  modport slave (
    input  i_addr_valid, i_write_enable, i_write_data_valid, i_read_data_ready, i_common,
    output o_addr_ready, o_write_data_ready, o_read_data_valid, o_read_data
  );

  modport master (
    output i_addr_valid, i_write_enable, i_write_data_valid, i_read_data_ready, i_common,
    input  o_addr_ready, o_write_data_ready, o_read_data_valid, o_read_data
  );

endinterface

// File: rtl/interconnect_reg_decode.sv
// Combinational address decode: byte address -> {valid, register index}.
module interconnect_reg_decode
  import interconnect_reg_slave_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned       NUM_REGS  = 16
) (
  input  logic [WORD_W-1:0]           addr,
  output logic                        valid,
  output logic [$clog2(NUM_REGS)-1:0] idx
);

  logic [WORD_W-1:0] off;
  logic [WORD_W-1:0] word_idx;

  always_comb begin
    off      = addr - BASE_ADDR;
    word_idx = off >> ALIGN_W;
    valid    = (addr >= BASE_ADDR) && (off[ALIGN_W-1:0] == '0) &&
               (word_idx < WORD_W'(NUM_REGS));
    idx      = word_idx[$clog2(NUM_REGS)-1:0];
  end

endmodule

// File: rtl/interconnect_reg_slave.sv
// Register-bank responder on the word interconnect: ID word, status snapshot
// and NUM_REGS-2 read/write control words.
module interconnect_reg_slave
  import interconnect_reg_slave_pkg::*;
#(
  parameter int unsigned       NUM_REGS     = 16,
  parameter logic [WORD_W-1:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [WORD_W-1:0] ID_VALUE     = 32'h5341_4B58,
  parameter int unsigned       READ_LATENCY = 1,
  parameter logic [WORD_W-1:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  interconnect_reg_slave_if.slave        bus,
  input  logic [WORD_W-1:0]              i_status,
  output logic [WORD_W*(NUM_REGS-2)-1:0] o_regs,
  output logic [NUM_REGS-1:0]            o_wr_pulse,
  output logic                           o_access_err,
  output logic                           o_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  state_t            state, state_next;
  logic [WORD_W-1:0] addr_q;
  logic              rw_q;
  logic [3:0]        lat_cnt;
  logic              dec_valid;
  logic [IDX_W-1:0]  dec_idx;
  logic [WORD_W-1:0] rd_src;
  logic              commit;
  logic              load;

  interconnect_reg_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS)
  ) u_decode (
    .addr  (addr_q),
    .valid (dec_valid),
    .idx   (dec_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (bus.i_addr_valid) state_next = ADDR_ACK;
      ADDR_ACK:   state_next = rw_q ? WAIT_WDATA : READ_WAIT;
      WAIT_WDATA: begin
        // A dropped write enable aborts the transaction silently.
        if (!bus.i_write_enable)         state_next = IDLE;
        else if (bus.i_write_data_valid) state_next = WDATA_ACK;
      end
      WDATA_ACK:  state_next = IDLE;
      READ_WAIT:  if (lat_cnt == '0) state_next = READ_VALID;
      READ_VALID: if (bus.i_read_data_ready) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  assign commit = (state == WAIT_WDATA) && bus.i_write_enable && bus.i_write_data_valid;
  assign load   = (state == READ_WAIT) && (lat_cnt == '0);

  assign bus.o_addr_ready       = (state == ADDR_ACK);
  assign bus.o_write_data_ready = (state == WDATA_ACK);
  assign bus.o_read_data_valid  = (state == READ_VALID);
  assign o_busy                 = (state != IDLE);

  always_comb begin
    rd_src = ERR_DATA;
    if (dec_valid) begin
      if (dec_idx == IDX_W'(REG_IDX_ID)) begin
        rd_src = ID_VALUE;
      end else if (dec_idx == IDX_W'(REG_IDX_STATUS)) begin
        rd_src = i_status;
      end else begin
        for (int unsigned i = 2; i < NUM_REGS; i++) begin
          if (dec_idx == IDX_W'(i)) rd_src = o_regs[WORD_W*(i-2) +: WORD_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q          <= '0;
      rw_q            <= 1'b0;
      lat_cnt         <= '0;
      o_regs          <= '0;
      o_wr_pulse      <= '0;
      o_access_err    <= 1'b0;
      bus.o_read_data <= '0;
    end else begin
      o_wr_pulse <= '0;
      if ((state == IDLE) && bus.i_addr_valid) begin
        addr_q <= bus.i_common;
        rw_q   <= bus.i_write_enable;
      end
      if (state == ADDR_ACK)                          lat_cnt <= 4'(READ_LATENCY - 1);
      else if ((state == READ_WAIT) && (lat_cnt != '0)) lat_cnt <= lat_cnt - 4'd1;
      if (load) begin
        bus.o_read_data <= rd_src;
        if (!dec_valid) o_access_err <= 1'b1;
      end
      if (commit) begin
        if (!dec_valid) begin
          o_access_err <= 1'b1;
        end else if (dec_idx == IDX_W'(REG_IDX_ID)) begin
          o_access_err           <= 1'b0;
          o_wr_pulse[REG_IDX_ID] <= 1'b1;
        end else if (dec_idx != IDX_W'(REG_IDX_STATUS)) begin
          o_wr_pulse[dec_idx] <= 1'b1;
          for (int unsigned i = 2; i < NUM_REGS; i++) begin
            if (dec_idx == IDX_W'(i)) o_regs[WORD_W*(i-2) +: WORD_W] <= bus.i_common;
          end
        end
      end
    end
  end

endmodule
